control_state_sequencer: RTL
============================

// Module: control_state_sequencer
// PURPOSE
//  Microstate register + next-state logic of the MIPS control unit: consumes the 7-bit State_Sel
//  from the instruction->state encoder and drives datapath control signals. Sequences fetch, decode,
//  execute; stalls on memory handshake (MOC); halts on memory timeout.
//  Sits between the instruction encoder and the datapath/memory interface.
// PARAMETERS
//  MOC_TIMEOUT  255  cycles waited for MOC in a memory state before bus-error halt (>=1)
//  CNT_W        8    watchdog counter width; MOC_TIMEOUT must fit in CNT_W bits
// PORTS
//  Clk        in   1  rising-edge clock
//  Reset_n    in   1  asynchronous, active-low reset
//  State_Sel  in   7  encoder output (5 ADDU, 6 SB, 10 BEQ, 0 unsupported)
//  MOC        in   1  memory operation complete, level, sampled on Clk
//  Cond       in   1  ALU zero/equal flag for BEQ
//  Cur_State  out  7  current microstate
//  PC_Ld, IR_Ld, MAR_Ld, MDR_Ld, RF_Ld  out 1 each  register load enables
//  PC_Src     out  1  0: PC+4, 1: branch target
//  MemEn      out  1  memory request;  MemRW out 1  1 read / 0 write
//  ALU_Op     out  3  0 pass, 1 ADD, 2 ADDU, 3 SUB
//  Illegal    out  1  one-cycle pulse: unsupported instruction decoded
//  Bus_Err    out  1  sticky: MOC timeout, core halted
// BEHAVIOUR
//  - Moore machine: all outputs decoded from registered state only; no input->output paths.
//  - Reset_n low: state <= 0 immediately, counter <= 0; every output 0. Mid-operation reset
//    aborts any memory cycle (MemEn drops asynchronously).
//  - States / outputs / next (1 cycle each unless noted):
//    0  RESET   none                                      -> 1
//    1  FETCH0  MAR_Ld                                    -> 2
//    2  FETCH1  MemEn, MemRW=1, MDR_Ld; waits              -> 3 on MOC
//    3  FETCH2  IR_Ld, PC_Ld, PC_Src=0                    -> 4
//    4  DECODE  none; samples State_Sel                   -> State_Sel if in {5,6,10}, else 12
//    5  ADDU    RF_Ld, ALU_Op=2                           -> 1
//    6  SB0     MAR_Ld, ALU_Op=1                          -> 7
//    7  SB1     MDR_Ld                                    -> 8
//    8  SB2     MemEn, MemRW=0; waits                     -> 1 on MOC
//    10 BEQ0    ALU_Op=3                                  -> 11 if Cond else 1
//    11 BEQ1    PC_Ld, PC_Src=1                           -> 1
//    12 ILLEG   Illegal                                   -> 1
//    127 HALT   Bus_Err                                   -> 127 (exit only by reset)
//  - Any other encoding reached -> 0 next cycle (self-recovery).
//  - Watchdog: counter cleared on entry to 2 or 8, +1 each cycle in 2/8 with MOC=0; when
//    counter == MOC_TIMEOUT-1 and MOC=0 -> HALT. MOC=1 on the limit cycle wins (normal advance).
//  - MOC latency: zero-wait MOC (high on first cycle of 2/8) gives 1-cycle memory state.
//  - Fetch->decode->ADDU round trip with zero-wait MOC = 5 cycles.
//  - State_Sel ignored outside DECODE; Cond ignored outside BEQ0.
// STRUCTURE
//  - Shared package control_pkg: state localparams (S_RESET..S_HALT), ALU_Op codes, State_Sel
//    codes shared with the encoder.
//  - Sub-module moc_watchdog (clear, enable, MOC -> timeout) holds counter and compare.
//  - Top: state register, next-state case, output decode case.
// TESTING
//  - Reset: hold Reset_n=0 -> all outputs 0, Cur_State=0; release -> 0,1,2 on successive edges.
//  - ADDU, MOC=1 always: State_Sel=5 -> states 1,2,3,4,5,1; RF_Ld=1 only in state 5, ALU_Op=2.
//  - SB, MOC delayed 3 cycles in state 8 -> MemEn=1, MemRW=0 for 4 cycles, then state 1.
//  - BEQ: Cond=1 -> 10,11 with PC_Src=1, PC_Ld=1; Cond=0 -> 10 then 1, PC_Ld never set.
//  - State_Sel=0 in DECODE -> state 12, Illegal high exactly 1 cycle, then fetch resumes.
//  - MOC held 0 in state 2, MOC_TIMEOUT=4 -> HALT after 4 cycles, Bus_Err sticky; MOC on 4th
//    cycle -> advances to 3 instead; Reset_n pulse mid-HALT -> state 0, Bus_Err=0.

Source files
------------

// File: rtl/control_pkg.sv
// control_pkg: shared definitions for the MIPS control unit.
//   state_t   : microstate encodings (S_RESET..S_HALT), 7 bits wide to match Cur_State
//   ALU_*     : ALU_Op codes driven to the datapath
//   SEL_*     : State_Sel codes produced by the instruction->state encoder
//   is_mem_state() : true for the states that wait on the memory handshake
package control_pkg;

  typedef enum logic [6:0] {
    S_RESET  = 7'd0,
    S_FETCH0 = 7'd1,
    S_FETCH1 = 7'd2,
    S_FETCH2 = 7'd3,
    S_DECODE = 7'd4,
    S_ADDU   = 7'd5,
    S_SB0    = 7'd6,
    S_SB1    = 7'd7,
    S_SB2    = 7'd8,
    S_BEQ0   = 7'd10,
    S_BEQ1   = 7'd11,
    S_ILLEG  = 7'd12,
    S_HALT   = 7'd127
  } state_t;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_ADDU = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;

  localparam logic [6:0] SEL_NONE = 7'd0;
  localparam logic [6:0] SEL_ADDU = 7'd5;
  localparam logic [6:0] SEL_SB   = 7'd6;
  localparam logic [6:0] SEL_BEQ  = 7'd10;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH1) || (s == S_SB2);
  endfunction

endpackage

// File: rtl/moc_watchdog.sv
// moc_watchdog: counts cycles spent waiting for MOC in a memory state.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : hold counter at zero (asserted whenever not in a memory state,
//                so the count always starts from zero on entry)
//   enable     : currently in a memory state
//   moc        : memory operation complete
//   timeout    : this is the last allowed cycle and MOC is still low
module moc_watchdog #(
  parameter int unsigned MOC_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic moc,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MOC_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable && !moc) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // MOC arriving on the limit cycle suppresses the timeout, so the
  // memory access completes normally.
  assign timeout = enable && !moc && (cnt_reg == LIMIT);

endmodule

// File: rtl/control_state_sequencer.sv
// control_state_sequencer: microstate register and next-state logic of the
// MIPS control unit (Moore machine; outputs depend only on the state register).
//   Clk, Reset_n  : clock, asynchronous active-low reset
//   State_Sel     : encoder output, sampled only in DECODE
//   MOC           : memory operation complete (level)
//   Cond          : ALU equal flag, sampled only in BEQ0
//   Cur_State     : current microstate
//   PC_Ld..RF_Ld  : register load enables
//   PC_Src        : 0 PC+4, 1 branch target
//   MemEn, MemRW  : memory request, 1 read / 0 write
//   ALU_Op        : ALU operation code
//   Illegal       : one-cycle pulse for an unsupported instruction
//   Bus_Err       : sticky halt after MOC timeout
module control_state_sequencer
  import control_pkg::*;
#(
  parameter int unsigned MOC_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [6:0] State_Sel,
  input  logic       MOC,
  input  logic       Cond,
  output logic [6:0] Cur_State,
  output logic       PC_Ld,
  output logic       IR_Ld,
  output logic       MAR_Ld,
  output logic       MDR_Ld,
  output logic       RF_Ld,
  output logic       PC_Src,
  output logic       MemEn,
  output logic       MemRW,
  output logic [2:0] ALU_Op,
  output logic       Illegal,
  output logic       Bus_Err
);

  state_t state_reg, state_next;
  logic   in_mem;
  logic   timeout;

  assign in_mem = is_mem_state(state_reg);

  moc_watchdog #(
    .MOC_TIMEOUT(MOC_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .clear  (!in_mem),
    .enable (in_mem),
    .moc    (MOC),
    .timeout(timeout)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_reg <= S_RESET;
    else          state_reg <= state_next;
  end

  assign Cur_State = state_reg;

  always_comb begin
    state_next = S_RESET;
    PC_Ld   = 1'b0;
    IR_Ld   = 1'b0;
    MAR_Ld  = 1'b0;
    MDR_Ld  = 1'b0;
    RF_Ld   = 1'b0;
    PC_Src  = 1'b0;
    MemEn   = 1'b0;
    MemRW   = 1'b0;
    ALU_Op  = ALU_PASS;
    Illegal = 1'b0;
    Bus_Err = 1'b0;
    case (state_reg)
      S_RESET:  state_next = S_FETCH0;
      S_FETCH0: begin
        MAR_Ld     = 1'b1;
        state_next = S_FETCH1;
      end
      S_FETCH1: begin
        MemEn  = 1'b1;
        MemRW  = 1'b1;
        MDR_Ld = 1'b1;
        if (timeout)  state_next = S_HALT;
        else if (MOC) state_next = S_FETCH2;
        else          state_next = S_FETCH1;
      end
      S_FETCH2: begin
        IR_Ld      = 1'b1;
        PC_Ld      = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (State_Sel)
          SEL_ADDU: state_next = S_ADDU;
          SEL_SB:   state_next = S_SB0;
          SEL_BEQ:  state_next = S_BEQ0;
          default:  state_next = S_ILLEG;
        endcase
      end
      S_ADDU: begin
        RF_Ld      = 1'b1;
        ALU_Op     = ALU_ADDU;
        state_next = S_FETCH0;
      end
      S_SB0: begin
        MAR_Ld     = 1'b1;
        ALU_Op     = ALU_ADD;
        state_next = S_SB1;
      end
      S_SB1: begin
        MDR_Ld     = 1'b1;
        state_next = S_SB2;
      end
      S_SB2: begin
        MemEn = 1'b1;
        if (timeout)  state_next = S_HALT;
        else if (MOC) state_next = S_FETCH0;
        else          state_next = S_SB2;
      end
      S_BEQ0: begin
        ALU_Op     = ALU_SUB;
        state_next = Cond ? S_BEQ1 : S_FETCH0;
      end
      S_BEQ1: begin
        PC_Ld      = 1'b1;
        PC_Src     = 1'b1;
        state_next = S_FETCH0;
      end
      S_ILLEG: begin
        Illegal    = 1'b1;
        state_next = S_FETCH0;
      end
      S_HALT: begin
        Bus_Err    = 1'b1;
        state_next = S_HALT;
      end
      // Unused encodings fall back to RESET with all outputs inactive.
      default: state_next = S_RESET;
    endcase
  end

endmodule
